// File: rtl/stage3_word_pack_ctrl.sv
// Stage-3 compressed-word merge controller: packs variable-length chunks into a
// 136-bit accumulator and emits fixed 68-bit words, with flush/pad sequencing.
//
// state | meaning
// RUN   | accept chunks, emit full words as they become available
// FLUSH | inputs blocked, drain remaining full words
// PAD   | emit the zero-padded partial word marked o_last
// DONE  | wait for the output register to drain, pulse o_flush_done
module stage3_word_pack_ctrl #(
   parameter int I_WIDTH     = 68,
   parameter int TOTAL_WIDTH = 136,
   parameter int LEN_WIDTH   = 7,
   parameter int FILL_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic [I_WIDTH-1:0]    i_data,
   input  logic [LEN_WIDTH-1:0]  i_len,
   output logic                  o_ready,
   input  logic                  i_flush,
   output logic                  o_flush_done,
   output logic                  o_valid,
   output logic [I_WIDTH-1:0]    o_word,
   output logic                  o_last,
   input  logic                  i_ready,
   output logic [FILL_WIDTH-1:0] o_fill
);

   typedef enum logic [1:0] {RUN, FLUSH, PAD, DONE} state_t;

   localparam logic [FILL_WIDTH-1:0] WORD_BITS = FILL_WIDTH'(I_WIDTH);
   localparam logic [LEN_WIDTH-1:0]  LEN_MAX   = LEN_WIDTH'(I_WIDTH);

   state_t                 state, state_nxt;
   logic [TOTAL_WIDTH-1:0] acc;
   logic [FILL_WIDTH-1:0]  fill;
   logic                   run_en;
   logic                   reg_free, emit_full, emit_pad, fire_in;
   logic [FILL_WIDTH-1:0]  fill_eff;
   logic [LEN_WIDTH-1:0]   len_sat;
   logic [I_WIDTH-1:0]     mask, chunk;
   logic [TOTAL_WIDTH-1:0] acc_base, acc_ins;

   assign o_fill = fill;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= RUN;
         run_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         run_en <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:   if (i_flush && run_en) state_nxt = FLUSH;
         FLUSH: if (fill < WORD_BITS) state_nxt = (fill != '0) ? PAD : DONE;
         PAD:   if (reg_free) state_nxt = DONE;
         DONE:  if (reg_free) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // fill_eff is the post-emission fill; inserts land above what stays behind
   always_comb begin
      reg_free     = !o_valid || i_ready;
      emit_full    = ((state == RUN) || (state == FLUSH)) && (fill >= WORD_BITS) && reg_free;
      emit_pad     = (state == PAD) && reg_free;
      fill_eff     = emit_full ? (fill - WORD_BITS) : fill;
      o_ready      = run_en && (state == RUN) && (fill_eff <= WORD_BITS);
      fire_in      = i_valid && o_ready;
      o_flush_done = (state == DONE) && reg_free;
   end

   always_comb begin
      len_sat  = (i_len > LEN_MAX) ? LEN_MAX : i_len;
      mask     = (len_sat == LEN_MAX) ? '1 : ((I_WIDTH'(1) << len_sat) - I_WIDTH'(1));
      chunk    = i_data & mask;
      acc_base = emit_full ? (acc >> I_WIDTH) : acc;
      acc_ins  = {{(TOTAL_WIDTH-I_WIDTH){1'b0}}, chunk} << fill_eff;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc  <= '0;
         fill <= '0;
      end else if (emit_pad) begin
         acc  <= '0;
         fill <= '0;
      end else begin
         acc  <= acc_base | (fire_in ? acc_ins : '0);
         fill <= fill_eff + (fire_in ? FILL_WIDTH'(len_sat) : '0);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_word  <= '0;
         o_last  <= 1'b0;
      end else if (emit_full) begin
         o_valid <= 1'b1;
         o_word  <= acc[I_WIDTH-1:0];
         o_last  <= 1'b0;
      end else if (emit_pad) begin
         o_valid <= 1'b1;
         o_word  <= acc[I_WIDTH-1:0];
         o_last  <= 1'b1;
      end else if (i_ready) begin
         o_valid <= 1'b0;
         o_last  <= 1'b0;
      end
   end

endmodule

// File: doc/stage3_word_pack_ctrl.md
Name: stage3_word_pack_ctrl

Overview:
Sequencing controller for the Stage-3 compressed-word merge path. It accepts variable-length compressed chunks of up to 68 bits and ORs each chunk into a 136-bit accumulator at the current fill pointer. It emits fixed 68-bit output words with a valid/ready handshake, and drains or zero-pads the remainder on flush. It sits between the Stage-3 compressor output and the downstream packed-word buffer.

Parameters:
I_WIDTH, 68, max chunk width and output word width
TOTAL_WIDTH, 136, accumulator width (must equal 2*I_WIDTH)
LEN_WIDTH, 7, width of chunk length field (ceil(log2(I_WIDTH+1)))
FILL_WIDTH, 8, width of fill counter (ceil(log2(TOTAL_WIDTH+1)))

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  chunk present
i_data  input  I_WIDTH  chunk, LSB-aligned; bits at or above i_len are ignored (masked)
i_len  input  LEN_WIDTH  valid bit count, 0..68; values >68 saturate to 68
o_ready  output  1  controller can accept a chunk this cycle
i_flush  input  1  single-cycle request: drain and pad the current contents
o_flush_done  output  1  one-cycle pulse when the flush completes
o_valid  output  1  o_word valid
o_word  output  I_WIDTH  packed output word
o_last  output  1  qualifies o_word as the final (padded) word of a flush
i_ready  input  1  downstream accepts o_word
o_fill  output  FILL_WIDTH  current accumulator fill in bits

Behaviour:
- Reset (async, i_rst_n=0): accumulator=0, fill=0, state=RUN, o_valid=0, o_word=0, o_last=0, o_flush_done=0, o_ready=0 while in reset. Reset mid-flush or mid-handshake discards all data with no output.
- States: RUN, FLUSH, PAD, DONE.
- Accept condition: fire_in = i_valid & o_ready. o_ready = (state==RUN) & (fill <= 68), where fill is the post-emission fill for this cycle. Because len<=68, an accepted chunk never overflows 136 bits.
- Insert: acc |= (i_data & mask(len)) << fill_eff; fill_eff = fill, or fill-68 when an emission occurs in the same cycle; new fill = fill_eff + len. len=0 is accepted with no change.
- Emission: the output register is free when !o_valid or (o_valid & i_ready). If fill>=68 and the register is free: o_word <= acc[67:0], acc <= acc>>68 (upper 68 bits are zero-filled), fill -= 68, o_valid <= 1. A simultaneous emit and insert in the same cycle is required, with no bubble.
- o_valid/o_word/o_last are held stable while o_valid & !i_ready.
- Throughput: 1 chunk/cycle sustained; output latency is 1 cycle from the cycle in which fill reaches >=68.
- Flush: i_flush in RUN moves to FLUSH next cycle; a chunk accepted in the same cycle as i_flush is included. i_flush outside RUN is ignored. o_ready=0 in FLUSH/PAD/DONE.
- FLUSH: keep emitting full words while fill>=68. When fill<68: if fill>0, go to PAD; else go to DONE.
- PAD: when the register is free, o_word <= acc[67:0] (bits at or above fill are already 0), o_last <= 1, o_valid <= 1, acc=0, fill=0, go to DONE.
- DONE: once the output register is drained (!o_valid, or i_ready this cycle), pulse o_flush_done for 1 cycle and go to RUN. A flush with fill==0 emits no word and produces only the o_flush_done pulse.
- o_last is 0 on all non-pad words. o_fill reflects the registered fill.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream with fill=40 and o_valid=1 -> o_valid=0, o_fill=0, o_word=0 immediately; after release o_ready=1, o_flush_done=0.
- Exact fill: two chunks len=34, data 0x3_5555_5555 then 0x2_AAAA_AAAA, i_ready=1 -> one word 0xA_AAAA_AAAB_5555_5555 on the cycle after the 2nd accept, o_fill=0, o_last=0.
- Spill: chunks len=68 of all-ones, then len=10 of 0x3FF, then len=68 of 0 -> word0=all-ones; word1 = 0x3FF in bits [9:0] with zeros above; o_fill=10 after word1; no accept cycles lost.
- Backpressure: i_ready=0 with fill reaching 136 -> o_ready=0, o_word held stable; release i_ready -> two words out on consecutive cycles, then o_ready=1.
- Flush with residue: fill=20 (data 0xFFFFF), pulse i_flush -> one word 0x0_0000_0000_000F_FFFF with o_last=1, then o_flush_done pulse; o_ready=1 again after that.
- Empty flush and masking: i_flush with fill=0 -> no o_valid, o_flush_done 2 cycles later. Chunk i_len=4 with i_data=all-ones -> only bits [3:0] set. i_len=100 -> treated as 68.
